// File: rtl/buttons_ctrl.sv
// Push-button bus responder: 2-FF synchroniser, per-bit debounce, sticky press flags,
// interrupt mask and a level interrupt on unmasked press events.
module buttons_ctrl #(
    parameter int NB      = 4,
    parameter int DEB_CYC = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          rd_en_i,
    input  logic          wr_en_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    input  logic [NB-1:0] buttons_i,
    output logic          irq_o
);

    localparam int              CW       = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);
    localparam logic [9:0]      OFS_LEVEL = 10'd0;
    localparam logic [9:0]      OFS_EDGE  = 10'd1;
    localparam logic [9:0]      OFS_MASK  = 10'd2;

    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] level_q, edge_q, mask_q;
    logic [NB-1:0] level_nxt, edge_nxt, mask_nxt, rise;
    logic [CW-1:0] cnt_q   [NB];
    logic [CW-1:0] cnt_nxt [NB];
    logic          bus_rd, bus_wr;
    logic [9:0]    word;
    logic [31:0]   rdata_nxt;
    logic          unused_bits;

    assign bus_rd      = en_i & rd_en_i;
    assign bus_wr      = en_i & wr_en_i;
    assign word        = addr_i[11:2];
    assign unused_bits = ^{addr_i[31:12], addr_i[1:0], wdata_i};

    // A bit's level only moves after DEB_CYC consecutive samples disagree with it.
    always_comb begin
        level_nxt = level_q;
        rise      = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_nxt[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_nxt[i] = sync2_q[i];
                    rise[i]      = sync2_q[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Set of a press event is applied after the W1C so a coincident press survives.
    always_comb begin
        edge_nxt = edge_q;
        mask_nxt = mask_q;
        if (bus_wr && word == OFS_EDGE) edge_nxt = edge_q & ~wdata_i[NB-1:0];
        if (bus_wr && word == OFS_MASK) mask_nxt = wdata_i[NB-1:0];
        edge_nxt = edge_nxt | rise;

        rdata_nxt = '0;
        if (bus_rd) begin
            case (word)
                OFS_LEVEL: rdata_nxt = 32'(level_q);
                OFS_EDGE:  rdata_nxt = 32'(edge_q);
                OFS_MASK:  rdata_nxt = 32'(mask_q);
                default:   rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            rdata_o <= '0;
            irq_o   <= 1'b0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= buttons_i;
            sync2_q <= sync1_q;
            level_q <= level_nxt;
            edge_q  <= edge_nxt;
            mask_q  <= mask_nxt;
            rdata_o <= rdata_nxt;
            irq_o   <= |(edge_nxt & mask_nxt);
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_nxt[i];
        end
    end

endmodule

// File: tb/tb_buttons_ctrl.sv
// Scoreboard bench for buttons_ctrl: driver steps a reference model and queues expectations,
// a monitor compares read data and irq after each clock edge.
module tb_buttons_ctrl;

    localparam int NB  = 4;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst, en, rd, wr;
    logic [31:0]   addr, wdata, rdata;
    logic [NB-1:0] btn;
    logic          irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_rd_q  [$];
    logic        exp_irq_q [$];

    // Reference model state
    logic [NB-1:0] m_level, m_edge, m_mask, m_p1, m_p2;
    logic [NB-1:0] m_hist [$];
    logic [NB-1:0] cur_btn;
    logic          mon_rd;

    buttons_ctrl #(.NB(NB), .DEB_CYC(DEB)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .rd_en_i(rd), .wr_en_i(wr),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
        .buttons_i(btn), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[11:2])
            10'd0:   return 32'(m_level);
            10'd1:   return 32'(m_edge);
            10'd2:   return 32'(m_mask);
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the model, using the currently driven inputs.
    task automatic model_edge();
        logic [NB-1:0] s, new_level, rise;
        bit            all_diff;
        if (rst) begin
            m_level = '0; m_edge = '0; m_mask = '0; m_p1 = '0; m_p2 = '0;
            m_hist.delete();
            exp_rd_q.push_back(32'h0);
            exp_irq_q.push_back(1'b0);
            return;
        end
        if (en && rd) exp_rd_q.push_back(m_read(addr));
        // Level follows the sync sample once the last DEB samples all disagree with it.
        s = m_p2;
        m_hist.push_back(s);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        new_level = m_level;
        rise = '0;
        for (int i = 0; i < NB; i++) begin
            all_diff = (m_hist.size() == DEB);
            foreach (m_hist[k]) if (m_hist[k][i] == m_level[i]) all_diff = 0;
            if (all_diff) begin
                new_level[i] = s[i];
                rise[i] = s[i];
            end
        end
        m_p2 = m_p1;
        m_p1 = btn;
        if (en && wr && addr[11:2] == 10'd1) m_edge = m_edge & ~wdata[NB-1:0];
        if (en && wr && addr[11:2] == 10'd2) m_mask = wdata[NB-1:0];
        m_edge  = m_edge | rise;
        m_level = new_level;
        exp_irq_q.push_back(|(m_edge & m_mask));
    endtask

    task automatic step(input logic r, input logic e, input logic rd_, input logic wr_,
                        input logic [31:0] a, input logic [31:0] wd);
        rst = r; en = e; rd = rd_; wr = wr_; addr = a; wdata = wd; btn = cur_btn;
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h7000_0000, 32'h0);
    endtask

    task automatic bus_read(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    // Monitor: each edge yields one irq expectation, and read data after a read or reset.
    always @(posedge clk) begin
        mon_rd = rst || (en && rd);
        #1;
        if (exp_irq_q.size() > 0) check32("irq", 32'(irq), 32'(exp_irq_q.pop_front()));
        if (mon_rd) begin
            if (exp_rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rdata_underflow: got %h expected none queued", rdata);
            end else begin
                check32("rdata", rdata, exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] addr_tbl [6];
        addr_tbl = '{32'h7000_0000, 32'h7000_0004, 32'h7000_0008,
                     32'h7000_000C, 32'h7000_0FFC, 32'h7000_0005};
        cur_btn = '0;

        // Reset and read every register
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus_read(32'h7000_0000);
        bus_read(32'h7000_0004);
        bus_read(32'h7000_0008);

        // Held press: LEVEL polled every cycle to pin the acceptance latency
        cur_btn = 4'b0001;
        for (int i = 0; i < 9; i++) bus_read(32'h7000_0000);
        bus_read(32'h7000_0004);

        // Short glitch rejected, minimal pulse accepted
        cur_btn = 4'b0101;
        for (int i = 0; i < 3; i++) bus_read(32'h7000_0000);
        cur_btn = 4'b0001;
        for (int i = 0; i < 8; i++) bus_read(32'h7000_0000);
        bus_read(32'h7000_0004);
        cur_btn = 4'b0101;
        for (int i = 0; i < 4; i++) bus_read(32'h7000_0000);
        cur_btn = 4'b0001;
        for (int i = 0; i < 8; i++) bus_read(32'h7000_0000);
        bus_read(32'h7000_0004);

        // Mask and W1C interrupt behaviour
        bus_write(32'h7000_0008, 32'hFFFF_FFFF);
        bus_read(32'h7000_0008);
        bus_write(32'h7000_0004, 32'h0000_0001);
        idle();
        bus_write(32'h7000_0004, 32'h0000_0004);
        idle();
        bus_read(32'h7000_0004);

        // W1C coinciding with the rising level of bit 1
        cur_btn = 4'b0011;
        for (int i = 0; i < 5; i++) idle();
        bus_write(32'h7000_0004, 32'h0000_0002);
        bus_read(32'h7000_0004);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h7000_0004, 32'h0000_0002);
        bus_read(32'h7000_0004);

        // Unmapped offsets, unselected write, reset mid-count
        bus_read(32'h7000_0010);
        bus_read(32'h7000_0FFC);
        cur_btn = 4'b1011;
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h7000_0004, 32'hFFFF_FFFF);
        bus_read(32'h7000_0004);
        bus_read(32'h7000_0000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h7000_0000, 32'h0);
        bus_read(32'h7000_0000);
        bus_read(32'h7000_0004);
        bus_read(32'h7000_0008);
        for (int i = 0; i < 8; i++) bus_read(32'h7000_0000);
        bus_read(32'h7000_0004);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, e, rr, ww;
            logic [31:0] a, d;
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 5) == 0) cur_btn[b] = ~cur_btn[b];
            r  = ($urandom_range(0, 399) == 0);
            e  = ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            ww = ($urandom_range(0, 4) == 0);
            a  = addr_tbl[$urandom_range(0, 5)];
            d  = $urandom();
            step(r, e, rr, ww, a, d);
        end

        for (int i = 0; i < 3; i++) idle();
        check32("scoreboard_drained", 32'(exp_rd_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
